// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit SRAM as two wait-stated
// half-word phases (low half first); ready low freezes the pipeline meanwhile.
module sram_controller #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_WDATA,
    input  logic [15:0]        SRAM_RDATA,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IW = SRAM_AW - 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_STATES);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          op_write;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic          req;
    logic          phase_end;
    logic [IW-1:0] new_idx;

    assign req       = MEM_R_EN | MEM_W_EN;
    assign phase_end = (wait_cnt == WAIT_LAST);
    // Word index relative to the data-memory base; out-of-range addresses wrap.
    assign new_idx   = IW'((address - 32'(ADDR_BASE)) >> 2);
    assign ready     = ~req | (state == S_DONE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, including SRAM_RDATA at phase end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            op_write   <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readData   <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (req) begin
                        // A simultaneous load is dropped in favour of the store.
                        op_write   <= MEM_W_EN;
                        idx_q      <= new_idx;
                        wdata_q    <= writeData;
                        SRAM_ADDR  <= {new_idx, 1'b0};
                        SRAM_WDATA <= writeData[15:0];
                        SRAM_WE_N  <= ~MEM_W_EN;
                        SRAM_OE_N  <= MEM_W_EN;
                        state      <= S_LO;
                    end
                end
                S_LO: begin
                    if (phase_end) begin
                        wait_cnt   <= '0;
                        SRAM_ADDR  <= {idx_q, 1'b1};
                        SRAM_WDATA <= wdata_q[31:16];
                        if (!op_write) begin
                            readData[15:0] <= SRAM_RDATA;
                        end
                        state <= S_HI;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_HI: begin
                    if (phase_end) begin
                        wait_cnt  <= '0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        if (!op_write) begin
                            readData[31:16] <= SRAM_RDATA;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
